// File: rtl/apb_timer_bank.sv
// apb_timer_bank: APB slave holding N_CH independent prescaled down-counters.
// Each channel has a reload register, one-shot or auto-reload mode and a sticky
// expiry flag. Expiries gated by their IRQ enables are ORed into one registered IRQ.
// Ports:
//   PCLK, PRESET        clock and asynchronous active-high reset
//   PSEL, PENABLE,      APB request; every access takes one wait state
//   PWRITE, PRWADDR,
//   PRWDATA
//   PRWDATA1, PREADY,   APB response (registered)
//   PSLVERR
//   IRQ                 OR over channels of EXPIRED & IRQ_EN, registered

// Timer channel: prescaler, down-counter, control fields and the sticky flag.
module apb_timer_ch #(
  parameter int CNT_W = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic        wr_stat,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] value_rd,
  output logic [31:0] stat_rd,
  output logic        irq_req
);
  logic             en, ar, ie, expired;
  logic [7:0]       pre, pcnt;
  logic [CNT_W-1:0] load, count;
  logic             tick, expire;
  logic             unused_w;

  assign tick   = en && (pcnt == pre);
  // A LOAD write on the same edge replaces the count, so no expiry happens.
  assign expire = tick && !wr_load && (count == '0);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      en      <= 1'b0;
      ar      <= 1'b0;
      ie      <= 1'b0;
      expired <= 1'b0;
      pre     <= '0;
      pcnt    <= '0;
      load    <= '0;
      count   <= '0;
    end else begin
      if (en) pcnt <= tick ? 8'd0 : pcnt + 8'd1;
      if (wr_load) begin
        load  <= wdata[CNT_W-1:0];
        count <= wdata[CNT_W-1:0];
        pcnt  <= '0;
      end else if (tick) begin
        if (count != '0)  count <= count - CNT_W'(1);
        else if (ar)      count <= load;
        else              en    <= 1'b0;
      end
      // Software control write comes last so it overrides the one-shot auto-clear.
      if (wr_ctrl) begin
        en  <= wdata[0];
        ar  <= wdata[1];
        ie  <= wdata[2];
        pre <= wdata[15:8];
      end
      // A fresh expiry wins over a simultaneous clear.
      if (expire)                   expired <= 1'b1;
      else if (wr_stat && wdata[0]) expired <= 1'b0;
    end
  end

  assign ctrl_rd  = {16'd0, pre, 5'd0, ie, ar, en};
  assign load_rd  = 32'(load);
  assign value_rd = 32'(count);
  assign stat_rd  = {31'd0, expired};
  assign irq_req  = expired && ie;
  assign unused_w = ^wdata;
endmodule

module apb_timer_bank #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 32
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PRWADDR,
  input  logic [31:0] PRWDATA,
  output logic [31:0] PRWDATA1,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);
  localparam logic [31:0] ADDR_TOP = 32'(N_CH * 16);

  logic [3:0]                 sel;
  logic [1:0]                 off;
  logic                       err, access, wr_ok;
  logic [31:0]                rdata;
  logic [N_CH-1:0]            wr_ctrl, wr_load, wr_stat, irq_req;
  logic [N_CH-1:0][31:0]      ctrl_rd, load_rd, value_rd, stat_rd;

  assign sel    = PRWADDR[7:4];
  assign off    = PRWADDR[3:2];
  assign err    = (PRWADDR >= ADDR_TOP) || (PRWADDR[1:0] != 2'd0) ||
                  (PWRITE && off == 2'd2);
  // Access phase is taken once; the registered PREADY blocks a second commit.
  assign access = PSEL && PENABLE && !PREADY;
  assign wr_ok  = access && PWRITE && !err;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      assign wr_ctrl[g] = wr_ok && (sel == 4'(g)) && (off == 2'd0);
      assign wr_load[g] = wr_ok && (sel == 4'(g)) && (off == 2'd1);
      assign wr_stat[g] = wr_ok && (sel == 4'(g)) && (off == 2'd3);
      apb_timer_ch #(.CNT_W(CNT_W)) u_ch (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .wr_ctrl  (wr_ctrl[g]),
        .wr_load  (wr_load[g]),
        .wr_stat  (wr_stat[g]),
        .wdata    (PRWDATA),
        .ctrl_rd  (ctrl_rd[g]),
        .load_rd  (load_rd[g]),
        .value_rd (value_rd[g]),
        .stat_rd  (stat_rd[g]),
        .irq_req  (irq_req[g])
      );
    end
  endgenerate

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == 4'(i)) begin
        case (off)
          2'd0:    rdata = ctrl_rd[i];
          2'd1:    rdata = load_rd[i];
          2'd2:    rdata = value_rd[i];
          default: rdata = stat_rd[i];
        endcase
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PRWDATA1 <= '0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      IRQ <= |irq_req;
      if (access) begin
        PREADY  <= 1'b1;
        PSLVERR <= err;
        if (err)          PRWDATA1 <= '0;
        else if (!PWRITE) PRWDATA1 <= rdata;
      end else begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_timer_bank.sv
module tb_apb_timer_bank;
  localparam int N_CH  = 2;
  localparam int CNT_W = 16;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PRWADDR = '0, PRWDATA = '0;
  logic [31:0] PRWDATA1;
  logic        PREADY, PSLVERR, IRQ;

  apb_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRWADDR(PRWADDR), .PRWDATA(PRWDATA), .PRWDATA1(PRWDATA1), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  int errors = 0, checks = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: register-level behaviour of each channel.
  typedef struct { logic [31:0] data; bit err; } rsp_t;
  rsp_t q[$];
  int m_en[N_CH], m_ar[N_CH], m_ie[N_CH], m_pre[N_CH];
  int m_load[N_CH], m_cnt[N_CH], m_pcnt[N_CH], m_exp[N_CH];
  bit m_rdy, m_irq;
  logic [31:0] m_prd;
  bit acc, er, wr, irq_n, tick, set;
  int c, o;

  function automatic logic [31:0] m_read(int ch, int of);
    case (of)
      0: return 32'((m_pre[ch] << 8) | (m_ie[ch] << 2) | (m_ar[ch] << 1) | m_en[ch]);
      1: return 32'(m_load[ch]);
      2: return 32'(m_cnt[ch]);
      default: return 32'(m_exp[ch]);
    endcase
  endfunction

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int k = 0; k < N_CH; k++) begin
        m_en[k] = 0; m_ar[k] = 0; m_ie[k] = 0; m_pre[k] = 0;
        m_load[k] = 0; m_cnt[k] = 0; m_pcnt[k] = 0; m_exp[k] = 0;
      end
      m_rdy = 0; m_irq = 0; m_prd = '0;
      q.delete();
    end else begin
      acc = PSEL && PENABLE && !m_rdy;
      c   = int'(PRWADDR[7:4]);
      o   = int'(PRWADDR[3:2]);
      er  = (PRWADDR >= 32'(N_CH * 16)) || (PRWADDR[1:0] != 2'd0) || (PWRITE && o == 2);
      wr  = acc && PWRITE && !er;
      irq_n = 0;
      for (int k = 0; k < N_CH; k++) if (m_exp[k] != 0 && m_ie[k] != 0) irq_n = 1;
      if (acc) begin
        if (er) m_prd = '0;
        else if (!PWRITE) m_prd = m_read(c, o);
        q.push_back('{m_prd, er});
      end
      for (int k = 0; k < N_CH; k++) begin
        tick = (m_en[k] != 0) && (m_pcnt[k] == m_pre[k]);
        if (m_en[k] != 0) m_pcnt[k] = tick ? 0 : (m_pcnt[k] + 1) % 256;
        set = 0;
        if (wr && c == k && o == 1) begin
          m_load[k] = int'(PRWDATA) & MASK;
          m_cnt[k]  = m_load[k];
          m_pcnt[k] = 0;
        end else if (tick) begin
          if (m_cnt[k] > 0) m_cnt[k]--;
          else begin
            set = 1;
            if (m_ar[k] != 0) m_cnt[k] = m_load[k];
            else m_en[k] = 0;
          end
        end
        if (wr && c == k && o == 0) begin
          m_en[k] = int'(PRWDATA[0]); m_ar[k] = int'(PRWDATA[1]);
          m_ie[k] = int'(PRWDATA[2]); m_pre[k] = int'(PRWDATA[15:8]);
        end
        if (set) m_exp[k] = 1;
        else if (wr && c == k && o == 3 && PRWDATA[0]) m_exp[k] = 0;
      end
      m_rdy = acc;
      m_irq = irq_n;
    end
  end

  // Monitor: handshake, IRQ and every completed response against the model.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      chk("pready", 32'(PREADY), 32'(m_rdy));
      chk("irq", 32'(IRQ), 32'(m_irq));
      if (PREADY && m_rdy) begin
        if (q.size() == 0) chk("rsp_queue_empty", 32'd1, 32'd0);
        else begin
          rsp_t r;
          r = q.pop_front();
          chk("rdata", PRWDATA1, r.data);
          chk("pslverr", 32'(PSLVERR), 32'(r.err));
        end
      end
    end
  end

  task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PRWADDR = a; PRWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (!PREADY && n < 4);
    chk("ready_latency", 32'(n), 32'd1);
    rd = PRWDATA1; e = PSLVERR;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
  endtask

  logic [31:0] rd, a, d;
  logic        e;

  initial begin
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_prdata", PRWDATA1, 32'd0);
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    PRESET = 1'b0;

    apb(0, 32'h04, 0, rd, e);
    chk("first_read_data", rd, 32'd0);
    chk("first_read_err", 32'(e), 32'd0);

    // Ch0 one-shot
    apb(1, 32'h04, 32'd3, rd, e);
    apb(1, 32'h00, 32'h1, rd, e);
    idle(10);
    apb(0, 32'h08, 0, rd, e); chk("oneshot_value", rd, 32'd0);
    apb(0, 32'h00, 0, rd, e); chk("oneshot_en_cleared", rd, 32'd0);
    apb(0, 32'h0C, 0, rd, e); chk("oneshot_expired", rd, 32'd1);
    apb(1, 32'h0C, 32'h1, rd, e);
    apb(0, 32'h0C, 0, rd, e); chk("w1c_cleared", rd, 32'd0);

    // Ch1 auto-reload with prescaler
    apb(1, 32'h14, 32'd2, rd, e);
    apb(1, 32'h10, 32'h0107, rd, e);
    for (int i = 0; i < 6; i++) apb(0, 32'h18, 0, rd, e);
    apb(1, 32'h1C, 32'h1, rd, e);
    idle(9);
    apb(1, 32'h1C, 32'h1, rd, e);
    idle(9);
    apb(1, 32'h10, 32'h0, rd, e);
    apb(1, 32'h1C, 32'h1, rd, e);

    // Ch0 expires every cycle, so the W1C always collides with an expiry
    apb(1, 32'h04, 32'd0, rd, e);
    apb(1, 32'h00, 32'h7, rd, e);
    idle(3);
    apb(1, 32'h0C, 32'h1, rd, e);
    apb(0, 32'h0C, 0, rd, e); chk("collide_expired", rd, 32'd1);
    chk("collide_irq", 32'(IRQ), 32'd1);
    apb(1, 32'h00, 32'h0, rd, e);

    // Decode errors
    apb(0, 32'h20, 0, rd, e);
    chk("oob_err", 32'(e), 32'd1); chk("oob_data", rd, 32'd0);
    apb(1, 32'h08, 32'h1234, rd, e); chk("ro_write_err", 32'(e), 32'd1);
    apb(0, 32'h02, 0, rd, e); chk("misalign_err", 32'(e), 32'd1);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      a = 32'(($urandom % 3) * 16 + ($urandom % 4) * 4);
      if ($urandom % 16 == 0) a = a + 32'd1;
      case (a[3:2])
        2'd0:    d = $urandom & 32'h0000_0307;
        2'd1:    d = ($urandom % 8 == 0) ? $urandom : ($urandom % 8);
        default: d = $urandom;
      endcase
      apb(($urandom % 2) == 1, a, d, rd, e);
      if ($urandom % 4 == 0) idle($urandom_range(1, 8));
    end

    // Reset in the middle of an access while ch1 is counting
    apb(1, 32'h14, 32'd100, rd, e);
    apb(1, 32'h10, 32'h1, rd, e);
    apb(0, 32'h14, 0, rd, e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PRWADDR = 32'h04; PRWDATA = 32'h55;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    #1;
    chk("midrst_prdata", PRWDATA1, 32'd0);
    chk("midrst_pready", 32'(PREADY), 32'd0);
    chk("midrst_pslverr", 32'(PSLVERR), 32'd0);
    chk("midrst_irq", 32'(IRQ), 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b0;
    apb(0, 32'h04, 0, rd, e); chk("midrst_load_not_committed", rd, 32'd0);
    chk("midrst_next_err", 32'(e), 32'd0);
    apb(0, 32'h18, 0, rd, e); chk("midrst_count_cleared", rd, 32'd0);
    apb(0, 32'h10, 0, rd, e); chk("midrst_ctrl_cleared", rd, 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
